// File: rtl/stream_downsize.sv
// Wide-to-narrow stream width converter: one wide beat of T_DATA_RATIO lanes out as narrow beats, lane 0 first.
// Optional STREAM_DOWNSIZE_SPARSE_KEEP_EN emits every kept lane; otherwise only the leading-ones keep run.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    drop_o
);

  localparam int IDX_W = $clog2(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] buf_mask;
  logic                    buf_last;
  logic                    buf_valid;
  logic [IDX_W-1:0]        idx;

  logic [T_DATA_RATIO-1:0] eff_mask;
  logic [T_DATA_RATIO-1:0] lanes_above;
  logic                    final_lane;
  logic                    s_fire;
  logic                    m_fire;

  function automatic logic [IDX_W-1:0] lowest_lane(input logic [T_DATA_RATIO-1:0] mask);
    lowest_lane = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lane = IDX_W'(i);
    end
  endfunction

`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
  always_comb begin
    eff_mask = s_keep_i;
  end
`else
  // Only the contiguous run of kept lanes starting at lane 0 is honoured
  always_comb begin
    logic run;
    eff_mask = '0;
    run      = 1'b1;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      run         = run & s_keep_i[i];
      eff_mask[i] = run;
    end
  end
`endif

  always_comb begin
    lanes_above = '0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (i > int'(idx)) lanes_above[i] = buf_mask[i];
    end
  end

  assign final_lane = (lanes_above == '0);
  assign m_fire     = buf_valid & m_ready_i;
  // Accepting on the final-lane handshake gives back-to-back wide beats with no bubble
  assign s_ready_o  = !rst && (!buf_valid || (m_ready_i && final_lane));
  assign s_fire     = s_valid_i & s_ready_o;

  assign m_valid_o = buf_valid;
  assign m_data_o  = buf_data[idx];
  assign m_last_o  = buf_valid & buf_last & final_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < T_DATA_RATIO; i++) buf_data[i] <= '0;
      buf_mask  <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
      idx       <= '0;
      drop_o    <= 1'b0;
    end else begin
      if (s_fire) begin
        buf_data  <= s_data_i;
        buf_mask  <= eff_mask;
        buf_last  <= s_last_i;
        buf_valid <= |eff_mask;
        idx       <= lowest_lane(eff_mask);
      end else if (m_fire) begin
        if (final_lane) buf_valid <= 1'b0;
        else            idx       <= lowest_lane(lanes_above);
      end
      drop_o <= s_fire && (eff_mask == '0);
    end
  end

endmodule
